// File: rtl/raisin64_pkg.sv
// Shared types and constants for the Raisin64 instruction-fetch responder.
//   imem_state_t        : responder FSM state encoding
//   RAISIN64_WORD_W     : instruction word width in bits
//   RAISIN64_WORD_BYTES : instruction word width in bytes
package raisin64_pkg;

  localparam int RAISIN64_WORD_W     = 64;
  localparam int RAISIN64_WORD_BYTES = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    READ = 3'd2,
    LOAD = 3'd3,
    RESP = 3'd4
  } imem_state_t;

endpackage

// File: rtl/imem_lasthit.sv
// Last-hit register for the instruction-fetch responder: remembers the most
// recently fetched word and its address so a repeat fetch can skip the RAM.
// Only instantiated when IMEM_RESP_LASTHIT_EN is defined.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   flush                : clears the valid bit at the next edge; also masks hit
//   load                 : capture load_addr/load_data as the new last-hit entry
//   load_addr, load_data : entry to capture
//   cmp_addr             : address compared against the stored entry
//   hit, hit_data        : combinational match result and stored word
module imem_lasthit
  import raisin64_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       load,
  input  logic [RAISIN64_WORD_W-1:0] load_addr,
  input  logic [RAISIN64_WORD_W-1:0] load_data,
  input  logic [RAISIN64_WORD_W-1:0] cmp_addr,
  output logic                       hit,
  output logic [RAISIN64_WORD_W-1:0] hit_data
);

  logic [RAISIN64_WORD_W-1:0] last_addr_q, last_addr_d;
  logic [RAISIN64_WORD_W-1:0] last_data_q, last_data_d;
  logic                       last_valid_q, last_valid_d;

  always_comb begin
    last_addr_d  = last_addr_q;
    last_data_d  = last_data_q;
    last_valid_d = last_valid_q;
    if (load) begin
      last_addr_d  = load_addr;
      last_data_d  = load_data;
      last_valid_d = 1'b1;
    end
    // Invalidation takes priority over a same-cycle load.
    if (flush) begin
      last_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr_q  <= '0;
      last_data_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_addr_q  <= last_addr_d;
      last_data_q  <= last_data_d;
      last_valid_q <= last_valid_d;
    end
  end

  // A flush in the same cycle as a lookup forces a real RAM read.
  assign hit      = last_valid_q && (cmp_addr == last_addr_q) && !flush;
  assign hit_data = last_data_q;

endmodule

// File: rtl/imem_responder.sv
// Responder end of the Raisin64 instruction-fetch interface. Accepts a fetch
// request, optionally waits WAIT_STATES cycles, reads the word from a
// synchronous single-port RAM and returns it with a one-cycle valid pulse.
// Misaligned or out-of-range requests return a fault without touching the RAM.
//
// Optional feature macro: IMEM_RESP_LASTHIT_EN -- adds a last-hit register so
// a repeat fetch of the previous address returns in one cycle with no RAM
// access; imem_flush invalidates it. Without the macro imem_flush is unused.
//
// Parameters: NUM_BYTES (RAM size, power of two, multiple of 8),
//             WAIT_STATES (0..15 extra cycles before each RAM read)
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   imem_addr, imem_addr_valid : fetch request (held until imem_data_valid)
//   imem_flush                 : last-hit invalidate
//   imem_data, imem_data_valid, imem_fault : registered response
//   ram_cs, ram_addr           : RAM read strobe and address
//   ram_dout                   : RAM read data, valid the cycle after ram_cs
//
// state | meaning
// IDLE  | waiting for a request; fault / last-hit check happens here
// WAIT  | counting down wait states before the RAM read
// READ  | ram_cs asserted for one cycle
// LOAD  | capture ram_dout (or drop it if the request was withdrawn)
// RESP  | imem_data_valid high for one cycle
module imem_responder
  import raisin64_pkg::*;
#(
  parameter int NUM_BYTES   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [RAISIN64_WORD_W-1:0] imem_addr,
  input  logic                       imem_addr_valid,
  input  logic                       imem_flush,
  output logic [RAISIN64_WORD_W-1:0] imem_data,
  output logic                       imem_data_valid,
  output logic                       imem_fault,
  output logic                       ram_cs,
  output logic [RAISIN64_WORD_W-1:0] ram_addr,
  input  logic [RAISIN64_WORD_W-1:0] ram_dout
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [RAISIN64_WORD_W-1:0] ADDR_LIMIT = RAISIN64_WORD_W'(NUM_BYTES);

  imem_state_t                state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [RAISIN64_WORD_W-1:0] addr_q, addr_d;
  logic                       abort_q, abort_d;
  logic [RAISIN64_WORD_W-1:0] data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       fault_q, fault_d;
  logic                       cs_q, cs_d;

  logic                       req_fault;
  logic                       lh_hit;
  logic [RAISIN64_WORD_W-1:0] lh_data;
  logic                       lh_load;

  assign req_fault = (imem_addr[2:0] != 3'b000) || (imem_addr >= ADDR_LIMIT);

`ifdef IMEM_RESP_LASTHIT_EN
  imem_lasthit u_lasthit (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (imem_flush),
    .load      (lh_load),
    .load_addr (addr_q),
    .load_data (ram_dout),
    .cmp_addr  (imem_addr),
    .hit       (lh_hit),
    .hit_data  (lh_data)
  );
`else
  logic unused_lasthit;
  assign unused_lasthit = imem_flush | lh_load;
  assign lh_hit  = 1'b0;
  assign lh_data = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    abort_d = abort_q;
    data_d  = data_q;
    valid_d = 1'b0;
    fault_d = fault_q;
    cs_d    = 1'b0;
    lh_load = 1'b0;

    case (state_q)
      IDLE: begin
        if (imem_addr_valid) begin
          addr_d  = imem_addr;
          abort_d = 1'b0;
          // Fault is checked before the last-hit so a faulting address never hits.
          if (req_fault) begin
            state_d = RESP;
            valid_d = 1'b1;
            fault_d = 1'b1;
            data_d  = '0;
          end else if (lh_hit) begin
            state_d = RESP;
            valid_d = 1'b1;
            fault_d = 1'b0;
            data_d  = lh_data;
          end else if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = READ;
            cs_d    = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!imem_addr_valid) abort_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = READ;
          cs_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READ: begin
        // A withdrawn request still lets the RAM access finish.
        if (!imem_addr_valid) abort_d = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        if (abort_q || !imem_addr_valid) begin
          state_d = IDLE;
          abort_d = 1'b0;
        end else begin
          state_d = RESP;
          data_d  = ram_dout;
          fault_d = 1'b0;
          valid_d = 1'b1;
          lh_load = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        fault_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      abort_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      abort_q <= abort_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      cs_q    <= cs_d;
    end
  end

  assign imem_data       = data_q;
  assign imem_data_valid = valid_q;
  assign imem_fault      = fault_q;
  assign ram_cs          = cs_q;
  assign ram_addr        = addr_q;

endmodule
